// File: rtl/vga_layer_arb.sv
`default_nettype none
// ============================================================================
//  Module      : vga_layer_arb
//  Description : Per-pixel layer arbiter for the VGA pipeline. Picks one of
//                three RGB565 sources (cursor > window > background) for each
//                active pixel. Layer geometry is written into staging
//                registers and copied to the shadow set only at frame start,
//                so a frame is never rendered with half-updated geometry.
//  Ports       : vga_clk, sys_rst_n       - 25 MHz clock, async active-low reset
//                pix_x, pix_y             - scan position (10'h3ff in blanking)
//                bg_data/win_data/cur_data- source colours
//                cfg_valid/addr/wdata     - staging register write port
//                cfg_commit               - apply staging at next frame start
//                cfg_ready                - write/commit accepted this cycle
//                pix_data                 - selected colour, one cycle late
//                frame_cnt                - 6-bit wrapping frame counter
//                commit_done              - one-cycle pulse on shadow update
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_layer_arb #(
    parameter int H_VALID  = 640,
    parameter int V_VALID  = 480,
    parameter int CUR_SIZE = 8
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [15:0] bg_data,
    input  logic [15:0] win_data,
    input  logic [15:0] cur_data,
    input  logic        cfg_valid,
    input  logic [2:0]  cfg_addr,
    input  logic [9:0]  cfg_wdata,
    input  logic        cfg_commit,
    output logic        cfg_ready,
    output logic [15:0] pix_data,
    output logic [5:0]  frame_cnt,
    output logic        commit_done
);

    localparam logic [0:0]  c_ST_IDLE  = 1'b0;
    localparam logic [0:0]  c_ST_PEND  = 1'b1;

    localparam logic [2:0]  c_A_WIN_X0 = 3'd0;
    localparam logic [2:0]  c_A_WIN_Y0 = 3'd1;
    localparam logic [2:0]  c_A_WIN_X1 = 3'd2;
    localparam logic [2:0]  c_A_WIN_Y1 = 3'd3;
    localparam logic [2:0]  c_A_CUR_X  = 3'd4;
    localparam logic [2:0]  c_A_CUR_Y  = 3'd5;
    localparam logic [2:0]  c_A_CTRL   = 3'd6;

    // Coordinates are compared 11 bits wide so cursor bounds near the
    // screen edge cannot wrap back to zero.
    localparam logic [10:0] c_H_VALID  = 11'(H_VALID);
    localparam logic [10:0] c_V_VALID  = 11'(V_VALID);
    localparam logic [10:0] c_CUR_SIZE = 11'(CUR_SIZE);

    logic [0:0]  r_state;

    // Staging set (written by the cfg port)
    logic [9:0]  r_stg_win_x0, r_stg_win_y0, r_stg_win_x1, r_stg_win_y1;
    logic [9:0]  r_stg_cur_x,  r_stg_cur_y;
    logic [2:0]  r_stg_ctrl;

    // Shadow set (used by the layer tests)
    logic [9:0]  r_shd_win_x0, r_shd_win_y0, r_shd_win_x1, r_shd_win_y1;
    logic [9:0]  r_shd_cur_x,  r_shd_cur_y;
    logic [2:0]  r_shd_ctrl;

    logic [5:0]  r_frame_cnt;
    logic        r_commit_done;
    logic [15:0] r_pix_data;

    logic        w_frame_start;
    logic [10:0] w_x, w_y;
    logic        w_active;
    logic        w_win_hit;
    logic [10:0] w_cur_x0, w_cur_y0, w_cur_x_end, w_cur_y_end;
    logic        w_cur_vis;
    logic        w_cur_hit;
    logic [15:0] w_pix_next;

    assign w_frame_start = (pix_x == 10'd0) && (pix_y == 10'd0);
    assign cfg_ready     = (r_state == c_ST_IDLE);
    assign frame_cnt     = r_frame_cnt;
    assign commit_done   = r_commit_done;
    assign pix_data      = r_pix_data;

    // ------------------------------------------------------------------
    // Commit FSM, staging/shadow registers and frame counter.
    // A write and a commit in the same IDLE cycle both take effect: the
    // write lands in staging now, and the shadow copy at the next frame
    // start picks it up.
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= c_ST_IDLE;
            r_stg_win_x0  <= '0;
            r_stg_win_y0  <= '0;
            r_stg_win_x1  <= '0;
            r_stg_win_y1  <= '0;
            r_stg_cur_x   <= '0;
            r_stg_cur_y   <= '0;
            r_stg_ctrl    <= '0;
            r_shd_win_x0  <= '0;
            r_shd_win_y0  <= '0;
            r_shd_win_x1  <= '0;
            r_shd_win_y1  <= '0;
            r_shd_cur_x   <= '0;
            r_shd_cur_y   <= '0;
            r_shd_ctrl    <= '0;
            r_frame_cnt   <= '0;
            r_commit_done <= 1'b0;
        end else begin
            r_commit_done <= 1'b0;
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 6'd1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (cfg_valid) begin
                        case (cfg_addr)
                            c_A_WIN_X0: r_stg_win_x0 <= cfg_wdata;
                            c_A_WIN_Y0: r_stg_win_y0 <= cfg_wdata;
                            c_A_WIN_X1: r_stg_win_x1 <= cfg_wdata;
                            c_A_WIN_Y1: r_stg_win_y1 <= cfg_wdata;
                            c_A_CUR_X:  r_stg_cur_x  <= cfg_wdata;
                            c_A_CUR_Y:  r_stg_cur_y  <= cfg_wdata;
                            c_A_CTRL:   r_stg_ctrl   <= cfg_wdata[2:0];
                            default:    ;
                        endcase
                    end
                    // A commit seen in the frame-start cycle waits for the
                    // following frame start.
                    if (cfg_commit) begin
                        r_state <= c_ST_PEND;
                    end
                end
                c_ST_PEND: begin
                    if (w_frame_start) begin
                        r_shd_win_x0  <= r_stg_win_x0;
                        r_shd_win_y0  <= r_stg_win_y0;
                        r_shd_win_x1  <= r_stg_win_x1;
                        r_shd_win_y1  <= r_stg_win_y1;
                        r_shd_cur_x   <= r_stg_cur_x;
                        r_shd_cur_y   <= r_stg_cur_y;
                        r_shd_ctrl    <= r_stg_ctrl;
                        r_commit_done <= 1'b1;
                        r_state       <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Layer hit tests, evaluated on the shadow set and the current
    // frame counter (the frame-start pixel still sees the old values).
    // ------------------------------------------------------------------
    assign w_x      = {1'b0, pix_x};
    assign w_y      = {1'b0, pix_y};
    assign w_active = (w_x < c_H_VALID) && (w_y < c_V_VALID);

    // X0 > X1 (or Y0 > Y1) naturally yields no hit.
    assign w_win_hit = r_shd_ctrl[0]
                     && (pix_x >= r_shd_win_x0) && (pix_x <= r_shd_win_x1)
                     && (pix_y >= r_shd_win_y0) && (pix_y <= r_shd_win_y1);

    assign w_cur_x0    = {1'b0, r_shd_cur_x};
    assign w_cur_y0    = {1'b0, r_shd_cur_y};
    assign w_cur_x_end = w_cur_x0 + c_CUR_SIZE;
    assign w_cur_y_end = w_cur_y0 + c_CUR_SIZE;

    // Blink: visible while frame_cnt[5] is low (32 frames on, 32 off).
    assign w_cur_vis = !r_shd_ctrl[2] || !r_frame_cnt[5];

    assign w_cur_hit = r_shd_ctrl[1] && w_cur_vis
                     && (w_x >= w_cur_x0) && (w_x < w_cur_x_end)
                     && (w_y >= w_cur_y0) && (w_y < w_cur_y_end);

    always_comb begin
        w_pix_next = 16'h0000;
        if (w_active) begin
            if (w_cur_hit) begin
                w_pix_next = cur_data;
            end else if (w_win_hit) begin
                w_pix_next = win_data;
            end else begin
                w_pix_next = bg_data;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pix_data <= 16'h0000;
        end else begin
            r_pix_data <= w_pix_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_layer_arb
//  Description : Scoreboard bench for vga_layer_arb. Stimulus drives scan
//                positions, random colours and cfg traffic on the falling
//                edge and pushes the expected post-edge outputs computed by
//                an integer reference model; a monitor pops and compares
//                shortly after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_layer_arb;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [9:0]  pix_x = 10'h3ff;
    logic [9:0]  pix_y = 10'h3ff;
    logic [15:0] bg_data = '0, win_data = '0, cur_data = '0;
    logic        cfg_valid = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [9:0]  cfg_wdata = '0;
    logic        cfg_commit = 1'b0;
    logic        cfg_ready;
    logic [15:0] pix_data;
    logic [5:0]  frame_cnt;
    logic        commit_done;

    vga_layer_arb #(.H_VALID(640), .V_VALID(480), .CUR_SIZE(8)) dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .bg_data     (bg_data),
        .win_data    (win_data),
        .cur_data    (cur_data),
        .cfg_valid   (cfg_valid),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .cfg_ready   (cfg_ready),
        .pix_data    (pix_data),
        .frame_cnt   (frame_cnt),
        .commit_done (commit_done)
    );

    always #20 vga_clk = ~vga_clk;

    typedef struct {
        int pix;
        int fc;
        int done;
        int rdy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: register files as plain integer arrays.
    // Index: 0 X0, 1 Y0, 2 X1, 3 Y1, 4 CUR_X, 5 CUR_Y, 6 CTRL.
    int  m_stg[7];
    int  m_shd[7];
    bit  m_pend;
    int  m_fc;

    int  xs[17] = '{0, 1, 2, 3, 99, 100, 101, 198, 199, 200, 320, 635, 636, 637, 639, 640, 1023};
    int  ys[14] = '{0, 49, 50, 51, 148, 149, 150, 240, 475, 476, 477, 479, 480, 1023};

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_stg[i] = 0;
            m_shd[i] = 0;
        end
        m_pend = 0;
        m_fc   = 0;
    endtask

    // One scan cycle: drive inputs, predict the outputs after the next edge.
    task automatic drive(input int x, input int y, input bit v = 0,
                         input int a = 0, input int d = 0, input bit c = 0);
        int bg, wd, cd, pix;
        bit active, win, vis, cur, rdy;
        exp_t e;
        bg = int'($urandom_range(0, 65535));
        wd = int'($urandom_range(0, 65535));
        cd = int'($urandom_range(0, 65535));
        @(negedge vga_clk);
        pix_x      = 10'(x);
        pix_y      = 10'(y);
        bg_data    = 16'(bg);
        win_data   = 16'(wd);
        cur_data   = 16'(cd);
        cfg_valid  = v;
        cfg_addr   = 3'(a);
        cfg_wdata  = 10'(d);
        cfg_commit = c;

        active = (x < 640) && (y < 480);
        win = ((m_shd[6] & 1) != 0) && (m_shd[0] <= x) && (x <= m_shd[2])
              && (m_shd[1] <= y) && (y <= m_shd[3]);
        vis = ((m_shd[6] & 4) == 0) || (m_fc < 32);
        cur = ((m_shd[6] & 2) != 0) && vis
              && (x >= m_shd[4]) && (x < m_shd[4] + 8)
              && (y >= m_shd[5]) && (y < m_shd[5] + 8);
        pix = !active ? 0 : (cur ? cd : (win ? wd : bg));

        rdy = !m_pend;
        if (rdy && v && a < 7) m_stg[a] = (a == 6) ? (d & 7) : d;
        e.done = 0;
        if (x == 0 && y == 0) begin
            m_fc = (m_fc + 1) % 64;
            if (m_pend) begin
                m_shd  = m_stg;
                e.done = 1;
                m_pend = 0;
            end
        end
        if (rdy && c) m_pend = 1;

        e.pix = pix;
        e.fc  = m_fc;
        e.rdy = m_pend ? 0 : 1;
        q.push_back(e);
    endtask

    // Everything of a frame except its (0,0) pixel.
    task automatic scan_body();
        int x, y;
        drive(1023, 1023);
        foreach (ys[j]) begin
            foreach (xs[i]) begin
                if (!(xs[i] == 0 && ys[j] == 0)) drive(xs[i], ys[j]);
            end
        end
        for (int k = 0; k < 20; k++) begin
            x = int'($urandom_range(0, 700));
            y = int'($urandom_range(0, 520));
            if (x == 0 && y == 0) x = 5;
            drive(x, y);
        end
    endtask

    // Monitor: compares each registered output against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge vga_clk);
            #1;
            if (sys_rst_n && q.size() > 0) begin
                e = q.pop_front();
                chk("pix_data",    int'(pix_data),    e.pix);
                chk("frame_cnt",   int'(frame_cnt),   e.fc);
                chk("commit_done", int'(commit_done), e.done);
                chk("cfg_ready",   int'(cfg_ready),   e.rdy);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge vga_clk);
        #1;
        chk("reset pix_data",    int'(pix_data),    0);
        chk("reset frame_cnt",   int'(frame_cnt),   0);
        chk("reset commit_done", int'(commit_done), 0);
        chk("reset cfg_ready",   int'(cfg_ready),   1);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;

        // Frame 0: background only.
        drive(0, 0);
        scan_body();

        // Frame 1: window + enable, committed mid-frame; writes while
        // pending must be dropped.
        drive(0, 0);
        drive(10, 10);
        drive(320, 240, 1, 0, 100);
        drive(321, 240, 1, 1, 50);
        drive(322, 240, 1, 2, 199);
        drive(323, 240, 1, 3, 149);
        drive(324, 240, 1, 6, 1, 1);
        drive(325, 240, 1, 0, 5);
        drive(326, 240, 0, 0, 0, 1);
        drive(327, 240, 1, 2, 7, 1);
        scan_body();

        // Frame 2: window applied. Queue cursor + grown window, with the
        // CTRL write and commit in the same cycle.
        drive(0, 0);
        scan_body();
        drive(20, 20, 1, 4, 636);
        drive(21, 20, 1, 5, 476);
        drive(22, 20, 1, 2, 639);
        drive(23, 20, 1, 3, 479);
        drive(24, 20, 1, 6, 3, 1);
        scan_body();

        // Frame 3: cursor over window at the screen corner. Then an
        // inverted window (X0 > X1).
        drive(0, 0);
        scan_body();
        drive(30, 30, 1, 0, 300);
        drive(31, 30, 1, 2, 200, 1);
        scan_body();
        drive(0, 0);
        scan_body();

        // Blink: stage CTRL=7, commit in the frame-start cycle itself.
        drive(40, 40, 1, 6, 7);
        drive(0, 0, 0, 0, 0, 1);
        scan_body();
        for (int f = 0; f < 66; f++) begin
            drive(0, 0);
            scan_body();
        end

        // Reset while a commit is pending at (320,240).
        drive(50, 50, 1, 6, 0, 1);
        drive(320, 240);
        @(posedge vga_clk);
        #5;
        sys_rst_n  = 1'b0;
        pix_x      = 10'h3ff;
        pix_y      = 10'h3ff;
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
        #1;
        chk("async rst pix_data",    int'(pix_data),    0);
        chk("async rst frame_cnt",   int'(frame_cnt),   0);
        chk("async rst commit_done", int'(commit_done), 0);
        chk("async rst cfg_ready",   int'(cfg_ready),   1);
        q.delete();
        model_reset();
        @(negedge vga_clk);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        drive(0, 0);
        scan_body();
        drive(0, 0);
        scan_body();

        repeat (3) @(posedge vga_clk);
        #2;
        chk("scoreboard drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_layer_arb.md
# vga_layer_arb

Pixel-source arbiter and display-layer scheduler between the pattern generators and `vga_ctrl`, in the 25 MHz VGA clock domain. Each active pixel, it selects one of three RGB565 sources: background, rectangular window, or 8x8 cursor. Layer geometry comes from a register-write port. Writes are staged and committed only at frame start, so a frame never tears mid-scan.

## Interface
Parameters:
- `H_VALID`, 640: active pixels per line.
- `V_VALID`, 480: active lines per frame.
- `CUR_SIZE`, 8: cursor box edge in pixels.

Ports:
- `vga_clk` input, 1 bit: 25 MHz VGA working clock.
- `sys_rst_n` input, 1 bit: asynchronous, active-low reset.
- `pix_x` input, 10 bits: current x from `vga_ctrl`; 10'h3ff outside the active area.
- `pix_y` input, 10 bits: current y from `vga_ctrl`; 10'h3ff outside the active area.
- `bg_data` input, 16 bits: background layer colour.
- `win_data` input, 16 bits: window layer colour.
- `cur_data` input, 16 bits: cursor layer colour.
- `cfg_valid` input, 1 bit: register write request.
- `cfg_addr` input, 3 bits: register select.
- `cfg_wdata` input, 10 bits: write data.
- `cfg_commit` input, 1 bit: request to apply staged registers at the next frame start.
- `cfg_ready` output, 1 bit: write/commit accepted this cycle.
- `pix_data` output, 16 bits: selected colour to `vga_ctrl`.
- `frame_cnt` output, 6 bits: frame counter.
- `commit_done` output, 1 bit: one-cycle pulse when staged registers are applied.

## Operation
- Register map, write-only (same map for staging and shadow):
  - 0 `WIN_X0`, 1 `WIN_Y0`, 2 `WIN_X1`, 3 `WIN_Y1`.
  - 4 `CUR_X`, 5 `CUR_Y`.
  - 6 `CTRL`: [0] `win_en`, [1] `cur_en`, [2] `blink_en`; only bits [2:0] are stored.
  - Address 7 is ignored.
- A write is accepted when `cfg_valid && cfg_ready`; it updates the staging register only.
- Commit FSM has two states:
  - IDLE: `cfg_ready`=1. On `cfg_commit` -> PEND.
  - PEND: `cfg_ready`=0, so writes and commits are ignored. On frame start: copy staging to shadow, pulse `commit_done`, go to IDLE.
- Frame start is the cycle with `pix_x==0 && pix_y==0`.
  - `frame_cnt` increments on frame start and wraps 63 -> 0.
- `cfg_valid` and `cfg_commit` in the same IDLE cycle: the write lands in staging first, and the commit includes it.
- Commit asserted in the frame-start cycle itself: the FSM enters PEND, and the commit applies at the following frame start.
- Layer tests use shadow values only.
  - Window hit: `win_en && WIN_X0<=x<=WIN_X1 && WIN_Y0<=y<=WIN_Y1`. X0>X1 or Y0>Y1 gives an empty window, never a wrap.
  - Cursor hit: `cur_en && cur_vis && CUR_X<=x<CUR_X+CUR_SIZE`, and the same test in y.
  - Cursor bounds are computed 11 bits wide, so CUR_X=636 covers x 636..639 and clips at the screen edge with no wrap to x=0.
  - `cur_vis` = `!blink_en || !frame_cnt[5]`, i.e. 32 frames on, 32 frames off.
- Priority: cursor > window > background.
- Outside the active area (`pix_x>=H_VALID` or `pix_y>=V_VALID`), `pix_data`=16'h0000.

## Timing
- `pix_data` is registered: the colour for the (`pix_x`,`pix_y`) seen in cycle N appears in cycle N+1.
  - This is the same one-cycle latency `vga_ctrl` already expects from `vga_pic`.
  - Source data inputs are sampled in cycle N, together with the coordinates.
- Shadow update, `frame_cnt` increment and the `commit_done` pulse all happen at the clock edge ending the frame-start cycle.
  - The pixel (0,0) itself is therefore evaluated with the old shadow values and the old `frame_cnt`.
  - Pixel (1,0) is evaluated with the new values.
- Reset values:
  - `pix_data`=0, `frame_cnt`=0, `commit_done`=0, `cfg_ready`=1, FSM=IDLE.
  - All staging and shadow registers = 0, so both layers are disabled and only the background is shown.
- Reset asserted mid-frame or mid-PEND: the pending commit is discarded and all of the above values apply immediately (asynchronous reset).

## Test plan
- Reset, then scan one full frame with `bg_data`=16'hF800 -> `pix_data`=16'hF800 on every active pixel one cycle late, 0 on blanking pixels, `frame_cnt`=1 after the frame.
- Write WIN=(100,50)-(199,149), CTRL=1, commit mid-frame -> `cfg_ready`=0 until the next (0,0); `commit_done` pulses once; in the following frame `win_data` appears exactly on x 100..199, y 50..149.
- Cursor at (636,476), CTRL=3, `cur_data`=16'h001F overlapping the window -> cursor colour on x 636..639, y 476..479 only; no wrap at x 0..3; cursor beats window where they overlap.
- `blink_en`=1 with cursor enabled -> cursor visible in frames 0..31, absent in 32..63, visible again from frame 64 (`frame_cnt` wrapped to 0).
- Write with `cfg_valid` held during PEND -> value not stored; the same write plus commit in a single IDLE cycle -> the new value is applied at the next frame start.
- Assert `sys_rst_n`=0 during PEND at pixel (320,240) -> all outputs return to reset values immediately; the pending commit is never applied.
